// File: rtl/asip_pkg.sv
`default_nettype none
// asip_pkg: shared fetch widths, FIFO entry and prefetch state types (rev 1.0).
package asip_pkg;

  localparam int INSTR_W = 24;
  localparam int ADDR_W  = 24;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } pf_state_t;

endpackage
`default_nettype wire

// File: rtl/pf_fifo.sv
`default_nettype none
// pf_fifo: DEPTH-entry fetch FIFO with synchronous flush; head is read straight from storage (rev 1.0).
module pf_fifo
  import asip_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  fetch_entry_t     push_data_i,
  input  logic             pop_i,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & ~flush_i & ~empty_o;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

  // Storage needs no reset: nothing reads an entry before it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset)
    !(push_i && !flush_i && full_o));

endmodule
`default_nettype wire

// File: rtl/inst_prefetch_buffer.sv
`default_nettype none
// inst_prefetch_buffer: credit-based instruction prefetcher with redirect flush/drain (rev 1.0).
// Build option PREFETCH_BYPASS_EN forwards a response straight to the outputs when the FIFO is empty.
module inst_prefetch_buffer
  import asip_pkg::fetch_entry_t;
  import asip_pkg::pf_state_t;
  import asip_pkg::RUN;
  import asip_pkg::DRAIN;
#(
  parameter int                DATA_W   = 24,
  parameter int                ADDR_W   = 24,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              deq,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  pf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  fetch_entry_t      fifo_head;
  fetch_entry_t      push_entry;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              handshake;
  logic              keep_resp;
  logic              bypass;
  logic              push;
  logic              pop;
  logic [CNT_W:0]    credit_used;

  // Counting in-flight requests against FIFO space guarantees every response has a slot.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outst_q};
  assign mem_req     = reset & (state_q == RUN) & (credit_used < (CNT_W+1)'(DEPTH));
  assign mem_addr    = fetch_pc_q;
  assign handshake   = mem_req & mem_ack;
  assign keep_resp   = mem_rvalid & (state_q == RUN) & ~redirect_valid;

`ifdef PREFETCH_BYPASS_EN
  assign bypass = keep_resp & fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  assign push       = keep_resp & ~(bypass & deq) & ~fifo_full;
  assign pop        = deq & ~fifo_empty & ~redirect_valid;
  assign push_entry = '{pc: resp_pc_q, instr: mem_rdata};
  assign out_valid  = ~fifo_empty | bypass;

  always_comb begin
    out_pc    = '0;
    out_instr = '0;
    if (!fifo_empty) begin
      out_pc    = fifo_head.pc;
      out_instr = fifo_head.instr;
    end else if (bypass) begin
      out_pc    = resp_pc_q;
      out_instr = mem_rdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    if (handshake) fetch_pc_d = fetch_pc_q + 1'b1;
    if (keep_resp) resp_pc_d  = resp_pc_q + 1'b1;
    if (redirect_valid) begin
      // Every request still in flight, plus one accepted now, becomes a response to discard.
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      outst_d    = '0;
      drop_d     = outst_q + drop_q + CNT_W'(handshake) - CNT_W'(mem_rvalid);
      state_d    = (drop_d == '0) ? RUN : DRAIN;
    end else if (state_q == DRAIN) begin
      if (mem_rvalid) begin
        drop_d = drop_q - 1'b1;
        if (drop_q == CNT_W'(1)) state_d = RUN;
      end
    end else begin
      if (handshake && !keep_resp) outst_d = outst_q + 1'b1;
      else if (!handshake && keep_resp) outst_d = outst_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  pf_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_inst_prefetch_buffer.sv
`default_nettype none
// tb_inst_prefetch_buffer: directed and randomized stimulus checked against a queue-level model.
module tb_inst_prefetch_buffer;

  localparam int            DW    = 24;
  localparam int            AW    = 24;
  localparam int            DEPTH = 4;
  localparam logic [AW-1:0] RPC   = 24'h000000;

  logic          clk = 1'b0;
  logic          reset;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          deq;
  logic          out_valid;
  logic [AW-1:0] out_pc;
  logic [DW-1:0] out_instr;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  inst_prefetch_buffer #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .DEPTH    (DEPTH),
    .RESET_PC (RPC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .deq            (deq),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata)
  );

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
    bit            live;
  } req_t;

  req_t          pend[$];   // requests accepted by the memory, oldest first
  logic [AW-1:0] q[$];      // PCs the FIFO should hold, head first
  logic [AW-1:0] exp_fetch;
  int            cyc, lat, last_due, hs_count, stall_en;
  int            n_cmp, n_bad;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a[11:0], a[23:12]} ^ 24'hC35A17;
  endfunction

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered just after a rising edge; leaves just after the next one.
  task automatic cycle_step();
    bit            dead, byp, exp_valid, exp_req, hs, keep, consumed;
    int            live_cnt, due;
    logic [AW-1:0] exp_pc;
    req_t          r;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (pend.size() != 0) begin
      if (pend[0].due <= cyc && (stall_en == 0 || $urandom_range(0, 3) != 0)) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(pend[0].addr);
      end
    end
    @(negedge clk);
    dead = 0;
    live_cnt = 0;
    foreach (pend[k]) begin
      if (pend[k].live) live_cnt++;
      else dead = 1;
    end
    byp = 0;
`ifdef PREFETCH_BYPASS_EN
    byp = (q.size() == 0) && !dead && mem_rvalid && !redirect_valid;
`endif
    exp_valid = (q.size() != 0) || byp;
    exp_pc = '0;
    if (q.size() != 0) exp_pc = q[0];
    else if (byp) exp_pc = pend[0].addr;
    check("out_valid", 48'(out_valid), 48'(exp_valid));
    check("out_pc", 48'(out_pc), 48'(exp_pc));
    check("out_instr", 48'(out_instr), exp_valid ? 48'(mem_word(exp_pc)) : 48'h0);
    exp_req = !dead && (q.size() + live_cnt < DEPTH);
    check("mem_req", 48'(mem_req), 48'(exp_req));
    if (exp_req) check("mem_addr", 48'(mem_addr), 48'(exp_fetch));

    hs = mem_req && mem_ack;
    keep = 0;
    consumed = 0;
    if (mem_rvalid) begin
      r = pend.pop_front();
      keep = r.live && !redirect_valid;
    end
    if (redirect_valid) begin
      q.delete();
      foreach (pend[k]) pend[k].live = 0;
    end else if (deq && exp_valid) begin
      if (q.size() != 0) void'(q.pop_front());
      else consumed = 1;
    end
    if (keep && !consumed) q.push_back(r.addr);
    if (hs) begin
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{addr: mem_addr, due: due, live: !redirect_valid});
      hs_count++;
    end
    if (redirect_valid) exp_fetch = redirect_pc;
    else if (hs) exp_fetch = exp_fetch + 1'b1;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle_step();
  endtask

  task automatic redirect_to(input logic [AW-1:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    cycle_step();
    redirect_valid = 1'b0;
  endtask

  // Asserted mid-cycle so the checks observe the asynchronous clear.
  task automatic do_reset();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    mem_rvalid     = 1'b0;
    mem_rdata      = '0;
    pend.delete();
    q.delete();
    exp_fetch = RPC;
    last_due  = cyc;
    #1;
    check("rst_out_valid", 48'(out_valid), 48'h0);
    check("rst_out_pc", 48'(out_pc), 48'h0);
    check("rst_out_instr", 48'(out_instr), 48'h0);
    check("rst_mem_req", 48'(mem_req), 48'h0);
    check("rst_mem_addr", 48'(mem_addr), 48'(RPC));
    repeat (2) @(posedge clk);
    cyc += 2;
    #1 reset = 1'b1;
  endtask

  initial begin
    int h0;
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; deq = 1'b0;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    n_cmp = 0; n_bad = 0; cyc = 0; lat = 1; last_due = 0; hs_count = 0; stall_en = 0;
    exp_fetch = RPC;
    #1;
    do_reset();

    // Streaming with 1-cycle memory and continuous dequeue.
    lat = 1; mem_ack = 1'b1; deq = 1'b1;
    run(12);

    // Back-pressure: credit limit caps requests at DEPTH.
    do_reset();
    deq = 1'b0;
    h0 = hs_count;
    run(10);
    check("t2_req_count", 48'(hs_count - h0), 48'(DEPTH));
    check("t2_req_low", 48'(mem_req), 48'h0);
    deq = 1'b1;
    run(8);

    // Redirect with three requests in flight at latency 3.
    lat = 3;
    redirect_to(24'h000005);
    run(4);
    redirect_to(24'h000100);
    check("t3_flushed", 48'(out_valid), 48'h0);
    run(10);

    // Redirect coinciding with a handshake and a response, deq ignored.
    lat = 2;
    run(6);
    redirect_to(24'h000200);
    check("t4_flushed", 48'(out_valid), 48'h0);
    run(8);

    // Address wrap at the top of the PC space.
    lat = 1;
    redirect_to(24'hFFFFFE);
    run(8);

    // Reset while draining.
    lat = 3;
    run(5);
    redirect_to(24'h000300);
    cycle_step();
    check("t6_draining", 48'(mem_req), 48'h0);
    do_reset();
    lat = 1;
    run(6);

    // Randomized traffic.
    stall_en = 1;
    for (int i = 0; i < 1500; i++) begin
      mem_ack = ($urandom_range(0, 3) != 0);
      deq     = ($urandom_range(0, 3) != 0);
      lat     = $urandom_range(1, 4);
      if ($urandom_range(0, 24) == 0) begin
        redirect_valid = 1'b1;
        if ($urandom_range(0, 1) == 1) redirect_pc = 24'($urandom);
        else redirect_pc = 24'hFFFFFC + 24'($urandom_range(0, 3));
      end else begin
        redirect_valid = 1'b0;
      end
      cycle_step();
    end
    redirect_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
